mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port 16-bit unified memory between the Fetch stage
//   (instruction reads) and the Memory stage (MAR-addressed loads/stores).
//   Runs a 4-state access sequencer with fixed memory latency and a
//   req/ack handshake per requester.
//   MEM-stage requests win by default; a streak limit prevents fetch starvation.
//   The pipeline stalls on a pending, un-acked request.
// PARAMETERS
//   ADDR_W      16  address width (MAR / PC width)
//   DATA_W      16  data width (AC / instruction word)
//   MEM_LAT     1   cycles from the mem_en cycle to valid mem_rdata; legal range >=1
//   MAX_STREAK  3   consecutive MEM grants allowed while if_req is pending
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       asynchronous reset, active-low
//   halt_program  in   1       1 = grant no new accesses
//   if_req        in   1       fetch read request; hold with if_addr until if_ack
//   if_addr       in   ADDR_W  fetch address (PC)
//   if_ack        out  1       1-cycle pulse: if_rdata valid
//   if_rdata      out  DATA_W  fetched word
//   ms_req        in   1       MEM-stage request; hold with payload until ms_ack
//   ms_we         in   1       1 = store, 0 = load
//   ms_addr       in   ADDR_W  data address (MAR)
//   ms_wdata      in   DATA_W  store data
//   ms_ack        out  1       1-cycle pulse: access done, ms_rdata valid for loads
//   ms_rdata      out  DATA_W  load data
//   mem_en        out  1       memory strobe, high exactly 1 cycle per access
//   mem_we        out  1       write enable, qualified by mem_en
//   mem_addr      out  ADDR_W  memory address
//   mem_wdata     out  DATA_W  memory write data
//   mem_rdata     in   DATA_W  memory read data
//   busy          out  1       1 whenever state != IDLE
// BEHAVIOUR
//   - All outputs are registered. rst=0 forces state IDLE, wait counter 0,
//     streak counter 0, and all outputs 0.
//   - IDLE: with halt_program=0 and a request present, grant on this edge and
//     go to ISSUE. Latch the winner, address, we and wdata into internal registers.
//     Grant rule: ms_req wins unless (if_req && streak==MAX_STREAK); then IF wins.
//     Only one request present: that requester wins.
//   - Streak counter:
//       MEM grant with if_req=1  -> increment, saturating at MAX_STREAK.
//       IF grant, or MEM grant with if_req=0 -> clear to 0.
//   - ISSUE (1 cycle): mem_en=1; mem_we/addr/wdata come from latched values.
//     Next state is WAIT.
//   - WAIT: lasts MEM_LAT cycles; counter width $clog2(MEM_LAT+1).
//     mem_rdata is sampled on the edge that ends the last WAIT cycle.
//     Next state is RESP.
//   - RESP (1 cycle): pulse the winner's ack. Its rdata holds the sampled word
//     (0 for stores) until that requester's next ack. Next state is IDLE.
//     Requests seen in RESP are ignored; the requester drops req after the ack.
//   - Latency: request seen in IDLE cycle N -> mem_en in N+1 -> ack in N+2+MEM_LAT.
//     Back-to-back grants start at the earliest in N+3+MEM_LAT.
//   - halt_program only blocks the IDLE grant. An in-flight access always
//     completes and acks. Requests are held un-acked while halted.
//   - Requester payload changes mid-access have no effect; latched values are used.
//   - rst low mid-access aborts it. No ack is issued, and the requester
//     re-requests after reset.
// TESTING
//   1. rst=0 with if_req=ms_req=1 -> all outputs 0; no mem_en until rst=1;
//      first grant goes to MEM.
//   2. MEM_LAT=1, if_req, if_addr=0x0010, mem_rdata=0xBEEF -> mem_en=1,
//      mem_addr=0x0010 at N+1; if_ack=1, if_rdata=0xBEEF at N+3 only.
//   3. if_req and ms_req (we=1, addr=0x0100, wdata=0x1234) in the same cycle ->
//      MEM first (mem_we=1, wdata 0x1234), ms_ack at N+3;
//      IF mem_en at N+5, if_ack at N+7.
//   4. ms_req and if_req held continuously, MAX_STREAK=3 -> grant order
//      MEM, MEM, MEM, IF, MEM...
//   5. halt_program=1 during WAIT of a fetch -> if_ack still issued.
//      A pending ms_req gets no mem_en while halted.
//      Deassert halt -> mem_en on the next cycle.
//   6. rst pulsed low during WAIT -> no ack, busy=0 immediately.
//      After release, the held request re-issues with the same latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the
// MEM stage: a four-state IDLE/ISSUE/WAIT/RESP sequencer with a fetch-starvation limit.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_program,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ms_req,
  input  logic              ms_we,
  input  logic [ADDR_W-1:0] ms_addr,
  input  logic [DATA_W-1:0] ms_wdata,
  output logic              ms_ack,
  output logic [DATA_W-1:0] ms_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W    = $clog2(MEM_LAT + 1);
  localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [CNT_W-1:0]    LAST_WAIT  = CNT_W'(MEM_LAT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                win_ms_q, win_ms_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                if_ack_q, if_ack_d;
  logic                ms_ack_q, ms_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ms_rdata_q, ms_rdata_d;
  logic                busy_q, busy_d;
  logic                grant_ms;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    streak_d   = streak_q;
    win_ms_d   = win_ms_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    ms_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ms_rdata_d = ms_rdata_q;
    // MEM wins unless fetch has already waited out a full streak of MEM grants
    grant_ms   = ms_req && !(if_req && (streak_q == STREAK_MAX));

    case (state_q)
      IDLE: begin
        if (!halt_program && (if_req || ms_req)) begin
          state_d  = ISSUE;
          win_ms_d = grant_ms;
          we_d     = grant_ms && ms_we;
          addr_d   = grant_ms ? ms_addr : if_addr;
          wdata_d  = grant_ms ? ms_wdata : '0;
          mem_en_d = 1'b1;
          mem_we_d = grant_ms && ms_we;
          if (grant_ms && if_req)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          else
            streak_d = '0;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d    = RESP;
          wait_cnt_d = '0;
          if (win_ms_q) begin
            ms_ack_d   = 1'b1;
            ms_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      streak_q   <= '0;
      win_ms_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      ms_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      ms_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      streak_q   <= streak_d;
      win_ms_q   <= win_ms_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      ms_ack_q   <= ms_ack_d;
      if_rdata_q <= if_rdata_d;
      ms_rdata_q <= ms_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign ms_ack    = ms_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ms_rdata  = ms_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a timestamp-level access model.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int MAXS = 3;

  logic          clk, rst, halt_program;
  logic          if_req, if_ack, ms_req, ms_we, ms_ack;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] if_addr, ms_addr, mem_addr;
  logic [DW-1:0] if_rdata, ms_wdata, ms_rdata, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst), .halt_program(halt_program),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ms_req(ms_req), .ms_we(ms_we), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
    .ms_ack(ms_ack), .ms_rdata(ms_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [8:0] a);
    if (a == 9'h010) return 16'hBEEF;
    if (a == 9'h022) return 16'h5A5A;
    return ({7'd0, a} * 16'd40503) ^ 16'h1357;
  endfunction

  // Memory seen by the DUT: one-cycle registered read.
  logic [15:0] tb_mem [512];
  bit          tb_wr  [512];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        tb_mem[mem_addr[8:0]] <= mem_wdata;
        tb_wr[mem_addr[8:0]]  <= 1'b1;
      end else begin
        mem_rdata <= tb_wr[mem_addr[8:0]] ? tb_mem[mem_addr[8:0]] : init_word(mem_addr[8:0]);
      end
    end
  end

  // Reference model: each grant is a scheduled event at absolute cycle numbers.
  logic [15:0] ref_mem [512];
  bit          ref_wr  [512];
  int          cyc = 0, issue_at = -1, ack_at = -1, free_at = 0, streak = 0;
  bit          m_win_ms, m_we, inflight_if, inflight_ms;
  logic [15:0] m_addr, m_wdata, m_rdata, exp_if_rdata, exp_ms_rdata;

  initial begin : model
    bit         e_en, e_busy, e_ifa, e_msa;
    logic [8:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        issue_at = -1; ack_at = -1; free_at = 0; streak = 0;
        inflight_if = 0; inflight_ms = 0;
        exp_if_rdata = '0; exp_ms_rdata = '0;
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {if_ack, ms_ack}, 0);
        check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_rdata", {if_rdata, ms_rdata}, 0);
      end else begin
        e_en   = (cyc == issue_at);
        e_busy = (cyc >= issue_at) && (cyc <= ack_at);
        if (e_en) begin
          a = m_addr[8:0];
          if (m_we) begin
            ref_mem[a] = m_wdata;
            ref_wr[a]  = 1'b1;
          end else begin
            m_rdata = ref_wr[a] ? ref_mem[a] : init_word(a);
          end
        end
        e_ifa = (cyc == ack_at) && !m_win_ms;
        e_msa = (cyc == ack_at) && m_win_ms;
        if (e_ifa) begin exp_if_rdata = m_rdata; inflight_if = 0; end
        if (e_msa) begin exp_ms_rdata = m_we ? 16'h0 : m_rdata; inflight_ms = 0; end

        check("mem_en", mem_en, e_en);
        check("busy", busy, e_busy);
        check("if_ack", if_ack, e_ifa);
        check("ms_ack", ms_ack, e_msa);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("ms_rdata", ms_rdata, exp_ms_rdata);
        if (e_en) begin
          check("mem_we", mem_we, m_we);
          check("mem_addr", mem_addr, m_addr);
          if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end

        if (cyc >= free_at && !halt_program && (if_req || ms_req)) begin
          m_win_ms = ms_req && !(if_req && streak == MAXS);
          if (m_win_ms) begin
            m_we = ms_we; m_addr = ms_addr; m_wdata = ms_wdata;
            streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            inflight_ms = 1;
          end else begin
            m_we = 0; m_addr = if_addr; m_wdata = '0;
            streak = 0;
            inflight_if = 1;
          end
          issue_at = cyc + 1;
          ack_at   = cyc + 2 + LAT;
          free_at  = cyc + 3 + LAT;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic await_ack(input bit is_ms, input string nm);
    int c = 0;
    bit seen = 0;
    while (!seen && c < 20) begin
      step();
      c++;
      seen = is_ms ? ms_ack : if_ack;
    end
    check(nm, seen, 1);
  endtask

  logic [15:0] t4_exp [5];
  logic [15:0] t4_got [5];

  initial begin : stim
    int got;
    rst = 1'b1; halt_program = 0;
    if_req = 0; if_addr = '0; ms_req = 0; ms_we = 0; ms_addr = '0; ms_wdata = '0;
    #1 rst = 1'b0;

    // Reset holds everything quiet even with both requests pending.
    if_req = 1; if_addr = 16'h0044; ms_req = 1; ms_addr = 16'h0033;
    repeat (3) begin
      step();
      check("t1_rst_mem_en", mem_en, 0);
      check("t1_rst_busy", busy, 0);
    end
    step(); rst = 1'b1;
    step();
    check("t1_first_en", mem_en, 1);
    check("t1_first_is_mem", mem_addr, 16'h0033);
    await_ack(1, "t1_ms_ack"); ms_req = 0;
    await_ack(0, "t1_if_ack"); if_req = 0;

    // Single fetch latency.
    step(); if_addr = 16'h0010; if_req = 1;
    step();
    check("t2_en", mem_en, 1);
    check("t2_addr", mem_addr, 16'h0010);
    step(); check("t2_no_early_ack", if_ack, 0);
    step();
    check("t2_ack", if_ack, 1);
    check("t2_rdata", if_rdata, 16'hBEEF);
    if_req = 0;
    step();
    check("t2_ack_pulse", if_ack, 0);
    check("t2_rdata_hold", if_rdata, 16'hBEEF);

    // Simultaneous store and fetch: store first, fetch reads it back.
    ms_req = 1; ms_we = 1; ms_addr = 16'h0100; ms_wdata = 16'h1234;
    if_req = 1; if_addr = 16'h0100;
    step();
    check("t3_st_en", mem_en, 1);
    check("t3_st_we", mem_we, 1);
    check("t3_st_wdata", mem_wdata, 16'h1234);
    step(); step();
    check("t3_ms_ack", ms_ack, 1);
    check("t3_if_not_yet", if_ack, 0);
    check("t3_store_rdata", ms_rdata, 16'h0000);
    ms_req = 0; ms_we = 0;
    step(); check("t3_gap", mem_en, 0);
    step();
    check("t3_if_en", mem_en, 1);
    check("t3_if_we", mem_we, 0);
    step(); step();
    check("t3_if_ack", if_ack, 1);
    check("t3_if_rdata", if_rdata, 16'h1234);
    if_req = 0;

    // Streak limit under continuous contention.
    step();
    t4_exp[0] = 16'h0055; t4_exp[1] = 16'h0055; t4_exp[2] = 16'h0055;
    t4_exp[3] = 16'h00AA; t4_exp[4] = 16'h0055;
    ms_req = 1; ms_we = 0; ms_addr = 16'h0055; if_req = 1; if_addr = 16'h00AA;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      step();
      if (mem_en) begin t4_got[got] = mem_addr; got++; end
    end
    ms_req = 0; if_req = 0;
    check("t4_grants", got, 5);
    for (int k = 0; k < 5; k++) check("t4_order", t4_got[k], t4_exp[k]);
    repeat (6) step();

    // Halt during a fetch: fetch still completes, new grant waits for release.
    if_addr = 16'h0020; if_req = 1;
    step(); step();
    halt_program = 1; ms_req = 1; ms_we = 0; ms_addr = 16'h0021;
    step();
    check("t5_ack_in_halt", if_ack, 1);
    if_req = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_halt_no_en", mem_en, 0);
    end
    halt_program = 0;
    step();
    check("t5_release_en", mem_en, 1);
    check("t5_release_addr", mem_addr, 16'h0021);
    await_ack(1, "t5_ms_ack"); ms_req = 0;

    // Reset mid-access aborts it; the held request replays with full latency.
    step();
    ms_req = 1; ms_we = 0; ms_addr = 16'h0022;
    step(); check("t6_en", mem_en, 1);
    step(); rst = 1'b0; #1;
    check("t6_busy_drop", busy, 0);
    check("t6_en_drop", mem_en, 0);
    step();
    check("t6_no_ack", ms_ack, 0);
    rst = 1'b1;
    step();
    check("t6_reissue_en", mem_en, 1);
    check("t6_reissue_addr", mem_addr, 16'h0022);
    step(); check("t6_no_early_ack", ms_ack, 0);
    step();
    check("t6_ack", ms_ack, 1);
    check("t6_rdata", ms_rdata, 16'h5A5A);
    ms_req = 0;
    step();

    // Randomized traffic with halts, reset pulses and payload churn after grant.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      halt_program = ($urandom_range(0, 9) < 2);
      if (ms_ack) ms_req = 0;
      else if (!ms_req) begin
        if ($urandom_range(0, 2) == 0) begin
          ms_req = 1; ms_we = 1'($urandom_range(0, 1));
          ms_addr = 16'($urandom_range(0, 511)); ms_wdata = 16'($urandom);
        end
      end else if (inflight_ms && $urandom_range(0, 3) == 0) begin
        ms_we = ~ms_we; ms_addr = 16'($urandom_range(0, 511)); ms_wdata = 16'($urandom);
      end
      if (if_ack) if_req = 0;
      else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = 16'($urandom_range(0, 511));
        end
      end else if (inflight_if && $urandom_range(0, 3) == 0) begin
        if_addr = 16'($urandom_range(0, 511));
      end
    end
    rst = 1'b1; halt_program = 0; if_req = 0; ms_req = 0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
